led_arbiter: RTL and testbench
==============================

Name: led_arbiter

Overview:
- Shares the board's user LED banks (LEDR[9:0], LEDG[9:0]) among NUM_REQ status sources, e.g. feed handler, order engine and error monitor.
- Round-robin arbitration: each grant snapshots the winner's pattern and displays it for a fixed minimum hold time.
- Optional blink per request; a heartbeat on LEDG[0] shows when no source owns the display.
- Sits between the status producers and the LED output pins.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- HOLD_CYCLES, 50_000_000: display hold time per grant, in clk cycles (>=1).
- BLINK_HALF, 12_500_000: blink half-period in cycles (>=1).
- HB_HALF, 25_000_000: idle heartbeat half-period in cycles (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-source display request, level.
- req_ledr  input  NUM_REQ*10  red pattern; source i uses bits [10i+9:10i].
- req_ledg  input  NUM_REQ*10  green pattern; same packing.
- req_blink  input  NUM_REQ  blink enable per source.
- grant  output  NUM_REQ  one-cycle, one-hot pulse: pattern captured.
- busy  output  1  high while a source owns the display.
- LEDR  output  10  red LEDs, registered.
- LEDG  output  10  green LEDs, registered.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - LEDR=0, LEDG=0, grant=0, busy=0.
  - state=IDLE; rr pointer=NUM_REQ-1, so req[0] wins first; all counters and phases 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: busy=0, LEDR=0, LEDG={9'b0,hb_phase}.
    - hb_phase and hb counter clear on IDLE entry.
    - hb_phase toggles when the counter reaches HB_HALF-1; the counter then wraps to 0.
  - SHOW: busy=1; LEDs display the latched pattern, gated by blink.
- Decision point: any IDLE cycle with req!=0, or the SHOW cycle where hold_cnt==HOLD_CYCLES-1.
- At a decision point, the winner is the first asserted req searching from pointer+1 upward, wrapping modulo NUM_REQ.
- Grant at the next clk edge:
  - Latch owner's req_ledr, req_ledg and req_blink slices from the sampled cycle.
  - Set pointer=owner and grant[owner]=1 for exactly one cycle.
  - Clear hold_cnt and blink counter; set blink_phase=1; enter or stay in SHOW.
- Latency: req rising in IDLE at cycle t -> grant pulse, busy=1 and the new pattern on LEDs all in cycle t+1.
- Back-to-back: if req is pending at a SHOW decision point, the next pattern appears on the following cycle with no blank cycle.
- If req==0 at a SHOW decision point -> IDLE next cycle; LEDs go to the heartbeat pattern with hb_phase=0.
- The current owner's req re-asserted is lowest priority. If it is the only requester, it is re-granted: new snapshot, new grant pulse.
- Requests that drop before a decision point are ignored; no request queueing.
- Patterns are snapshots: input changes after grant have no effect until the next grant.
- Blink:
  - Latched blink=1: output pattern when blink_phase=1, zeros when 0.
  - blink_phase toggles every BLINK_HALF cycles from grant.
  - Latched blink=0: pattern shown steadily.
- Counter widths: $clog2 of the respective parameter (minimum 1 bit); saturation is never reached.
- HOLD_CYCLES=1: a decision point every SHOW cycle.

Test Plan (NUM_REQ=4, HOLD_CYCLES=8, BLINK_HALF=2, HB_HALF=4):
- Reset, then no requests for 20 cycles -> LEDR=0, busy=0, grant=0; LEDG toggles 0x000/0x001 every 4 cycles.
- req=4'b0001 at t with LEDR0=0x2AA, LEDG0=0x155, blink0=0; drop req at t+1 -> grant=0001 at t+1 only; LEDR=0x2AA, LEDG=0x155 for cycles t+1..t+8; IDLE with LEDG=0 at t+9.
- req=4'b1111 held continuously -> grants in order 0,1,2,3,0, each 8 cycles apart, with no blank cycle between patterns.
- blink2=1, LEDR2=0x3FF requested alone -> LEDR sequence 0x3FF,0x3FF,0,0,0x3FF,0x3FF,0,0 over the 8-cycle hold.
- Change req_ledr0 to 0x001 three cycles after grant -> LEDR stays at the latched value until the hold ends.
- Assert rst mid-SHOW at hold_cnt=4 -> all outputs 0 immediately; after release, req[3] alone is granted first, and req[0] wins over req[3] when both are asserted.

Source files
------------

// File: rtl/led_arbiter.sv
// Round-robin owner of the user LED banks: snapshots the winning source's
// pattern, holds it for HOLD_CYCLES, optional blink, heartbeat when idle.
module led_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000,
  parameter int HB_HALF     = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*10-1:0] req_ledr,
  input  logic [NUM_REQ*10-1:0] req_ledg,
  input  logic [NUM_REQ-1:0]    req_blink,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic [9:0]            LEDR,
  output logic [9:0]            LEDG
);

  localparam int unsigned NR  = NUM_REQ;
  localparam int          PW  = $clog2(NUM_REQ);
  localparam int          HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int          BW  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int          HBW = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  logic [0:0]         r_state,       w_nxt_state;
  logic [PW-1:0]      r_ptr,         w_nxt_ptr;
  logic [HW-1:0]      r_hold_cnt,    w_nxt_hold_cnt;
  logic [BW-1:0]      r_blink_cnt,   w_nxt_blink_cnt;
  logic               r_blink_phase, w_nxt_blink_phase;
  logic [HBW-1:0]     r_hb_cnt,      w_nxt_hb_cnt;
  logic               r_hb_phase,    w_nxt_hb_phase;
  logic [9:0]         r_pat_r,       w_nxt_pat_r;
  logic [9:0]         r_pat_g,       w_nxt_pat_g;
  logic               r_pat_blink,   w_nxt_pat_blink;
  logic [NUM_REQ-1:0] r_grant,       w_nxt_grant;
  logic               r_busy;
  logic [9:0]         r_ledr,        w_nxt_ledr;
  logic [9:0]         r_ledg,        w_nxt_ledg;

  logic               w_found;
  logic [PW-1:0]      w_win;
  logic               w_decide;

  function automatic logic [PW-1:0] f_wrap(input int unsigned v);
    return PW'(v % NR);
  endfunction

  // Search starts just above the last owner, so the owner itself is checked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      if (!w_found && req[f_wrap(32'(r_ptr) + k)]) begin
        w_found = 1'b1;
        w_win   = f_wrap(32'(r_ptr) + k);
      end
    end
  end

  assign w_decide = (r_state == ST_IDLE) ? (req != '0)
                                         : (r_hold_cnt == HW'(HOLD_CYCLES - 1));

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_ptr         = r_ptr;
    w_nxt_hold_cnt    = r_hold_cnt;
    w_nxt_blink_cnt   = r_blink_cnt;
    w_nxt_blink_phase = r_blink_phase;
    w_nxt_hb_cnt      = r_hb_cnt;
    w_nxt_hb_phase    = r_hb_phase;
    w_nxt_pat_r       = r_pat_r;
    w_nxt_pat_g       = r_pat_g;
    w_nxt_pat_blink   = r_pat_blink;
    w_nxt_grant       = '0;
    if (w_decide && w_found) begin
      w_nxt_state        = ST_SHOW;
      w_nxt_ptr          = w_win;
      w_nxt_hold_cnt     = '0;
      w_nxt_blink_cnt    = '0;
      w_nxt_blink_phase  = 1'b1;
      w_nxt_pat_r        = req_ledr[32'(w_win)*10 +: 10];
      w_nxt_pat_g        = req_ledg[32'(w_win)*10 +: 10];
      w_nxt_pat_blink    = req_blink[w_win];
      w_nxt_grant[w_win] = 1'b1;
    end else if (r_state == ST_SHOW && w_decide) begin
      w_nxt_state    = ST_IDLE;
      w_nxt_hb_cnt   = '0;
      w_nxt_hb_phase = 1'b0;
    end else if (r_state == ST_SHOW) begin
      w_nxt_hold_cnt = r_hold_cnt + HW'(1);
      if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
        w_nxt_blink_cnt   = '0;
        w_nxt_blink_phase = ~r_blink_phase;
      end else begin
        w_nxt_blink_cnt = r_blink_cnt + BW'(1);
      end
    end else begin
      if (r_hb_cnt == HBW'(HB_HALF - 1)) begin
        w_nxt_hb_cnt   = '0;
        w_nxt_hb_phase = ~r_hb_phase;
      end else begin
        w_nxt_hb_cnt = r_hb_cnt + HBW'(1);
      end
    end
  end

  // LED registers are fed from next-state values so a grant shows its pattern in the same cycle as the pulse.
  always_comb begin
    w_nxt_ledr = '0;
    w_nxt_ledg = {9'b0, w_nxt_hb_phase};
    if (w_nxt_state == ST_SHOW) begin
      w_nxt_ledg = '0;
      if (!w_nxt_pat_blink || w_nxt_blink_phase) begin
        w_nxt_ledr = w_nxt_pat_r;
        w_nxt_ledg = w_nxt_pat_g;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= PW'(NUM_REQ - 1);
      r_hold_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_hb_cnt      <= '0;
      r_hb_phase    <= 1'b0;
      r_pat_r       <= '0;
      r_pat_g       <= '0;
      r_pat_blink   <= 1'b0;
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_ledr        <= '0;
      r_ledg        <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_ptr         <= w_nxt_ptr;
      r_hold_cnt    <= w_nxt_hold_cnt;
      r_blink_cnt   <= w_nxt_blink_cnt;
      r_blink_phase <= w_nxt_blink_phase;
      r_hb_cnt      <= w_nxt_hb_cnt;
      r_hb_phase    <= w_nxt_hb_phase;
      r_pat_r       <= w_nxt_pat_r;
      r_pat_g       <= w_nxt_pat_g;
      r_pat_blink   <= w_nxt_pat_blink;
      r_grant       <= w_nxt_grant;
      r_busy        <= (w_nxt_state == ST_SHOW);
      r_ledr        <= w_nxt_ledr;
      r_ledg        <= w_nxt_ledg;
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign LEDR  = r_ledr;
  assign LEDG  = r_ledg;

endmodule

// File: tb/tb_led_arbiter.sv
// Bench for led_arbiter: per-cycle vector table plus hand sequences, checked
// through an expected-output queue one clock after each stimulus.
module tb_led_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] req_ledr;
  logic [39:0] req_ledg;
  logic [3:0]  req_blink;
  logic [3:0]  grant;
  logic        busy;
  logic [9:0]  LEDR;
  logic [9:0]  LEDG;

  led_arbiter #(
    .NUM_REQ    (4),
    .HOLD_CYCLES(8),
    .BLINK_HALF (2),
    .HB_HALF    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_ledr (req_ledr),
    .req_ledg (req_ledg),
    .req_blink(req_blink),
    .grant    (grant),
    .busy     (busy),
    .LEDR     (LEDR),
    .LEDG     (LEDG)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic [3:0]  rq;
    logic [3:0]  g;
    logic        b;
    logic [9:0]  r;
    logic [9:0]  gn;
  } vec_t;

  typedef struct {
    string      nm;
    logic [3:0] g;
    logic       b;
    logic [9:0] r;
    logic [9:0] gn;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input int unsigned n, input logic [3:0] rq, input logic [3:0] g,
                     input logic b, input logic [9:0] r, input logic [9:0] gn);
    vec_t v;
    v.n = n; v.rq = rq; v.g = g; v.b = b; v.r = r; v.gn = gn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] g, input logic b,
                     input logic [9:0] r, input logic [9:0] gn);
    n_checks++;
    if (grant !== g || busy !== b || LEDR !== r || LEDG !== gn)
      $display("FAIL %s: got grant=%b busy=%b LEDR=%h LEDG=%h, want grant=%b busy=%b LEDR=%h LEDG=%h",
               nm, grant, busy, LEDR, LEDG, g, b, r, gn);
    else
      n_pass++;
  endtask

  // Called at a falling edge: drive, queue the expectation, compare after the next rising edge.
  task automatic step(input logic [3:0] rq, input logic [3:0] g, input logic b,
                      input logic [9:0] r, input logic [9:0] gn, input string nm);
    exp_t e;
    req = rq;
    e.nm = nm; e.g = g; e.b = b; e.r = r; e.gn = gn;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got nothing, want one entry", nm);
    end else begin
      e = sb_q.pop_front();
      chk(e.nm, e.g, e.b, e.r, e.gn);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_ledr  = {10'h104, 10'h3FF, 10'h011, 10'h2AA};
    req_ledg  = {10'h208, 10'h0F0, 10'h022, 10'h155};
    req_blink = 4'b0100;

    // idle heartbeat after reset
    add(3, 4'h0, 4'h0, 1'b0, 10'h000, 10'h000);
    add(4, 4'h0, 4'h0, 1'b0, 10'h000, 10'h001);
    add(4, 4'h0, 4'h0, 1'b0, 10'h000, 10'h000);
    add(4, 4'h0, 4'h0, 1'b0, 10'h000, 10'h001);
    add(4, 4'h0, 4'h0, 1'b0, 10'h000, 10'h000);
    add(1, 4'h0, 4'h0, 1'b0, 10'h000, 10'h001);
    // all four requesting: 0,1,2(blinking),3,0 with no gap
    add(1, 4'hF, 4'h1, 1'b1, 10'h2AA, 10'h155);
    add(7, 4'hF, 4'h0, 1'b1, 10'h2AA, 10'h155);
    add(1, 4'hF, 4'h2, 1'b1, 10'h011, 10'h022);
    add(7, 4'hF, 4'h0, 1'b1, 10'h011, 10'h022);
    add(1, 4'hF, 4'h4, 1'b1, 10'h3FF, 10'h0F0);
    add(1, 4'hF, 4'h0, 1'b1, 10'h3FF, 10'h0F0);
    add(2, 4'hF, 4'h0, 1'b1, 10'h000, 10'h000);
    add(2, 4'hF, 4'h0, 1'b1, 10'h3FF, 10'h0F0);
    add(2, 4'hF, 4'h0, 1'b1, 10'h000, 10'h000);
    add(1, 4'hF, 4'h8, 1'b1, 10'h104, 10'h208);
    add(7, 4'hF, 4'h0, 1'b1, 10'h104, 10'h208);
    add(1, 4'hF, 4'h1, 1'b1, 10'h2AA, 10'h155);
    add(7, 4'hF, 4'h0, 1'b1, 10'h2AA, 10'h155);
    // owner alone re-granted; a short req[1] pulse mid-hold is ignored
    add(1, 4'h1, 4'h1, 1'b1, 10'h2AA, 10'h155);
    add(1, 4'h0, 4'h0, 1'b1, 10'h2AA, 10'h155);
    add(1, 4'h2, 4'h0, 1'b1, 10'h2AA, 10'h155);
    add(5, 4'h0, 4'h0, 1'b1, 10'h2AA, 10'h155);
    add(1, 4'h0, 4'h0, 1'b0, 10'h000, 10'h000);
    add(3, 4'h0, 4'h0, 1'b0, 10'h000, 10'h000);
    add(1, 4'h0, 4'h0, 1'b0, 10'h000, 10'h001);

    repeat (2) @(negedge clk);
    chk("reset_state", 4'h0, 1'b0, 10'h000, 10'h000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      for (int unsigned j = 0; j < vecs[i].n; j++)
        step(vecs[i].rq, vecs[i].g, vecs[i].b, vecs[i].r, vecs[i].gn,
             $sformatf("vec%0d_%0d", i, j));
    end

    // snapshot: source 0 changes its pattern three cycles after the grant
    step(4'h1, 4'h1, 1'b1, 10'h2AA, 10'h155, "snap_grant");
    repeat (2) step(4'h0, 4'h0, 1'b1, 10'h2AA, 10'h155, "snap_hold");
    req_ledr[9:0] = 10'h001;
    repeat (5) step(4'h0, 4'h0, 1'b1, 10'h2AA, 10'h155, "snap_latched");
    step(4'h0, 4'h0, 1'b0, 10'h000, 10'h000, "snap_idle");
    step(4'h1, 4'h1, 1'b1, 10'h001, 10'h155, "snap_new");
    repeat (4) step(4'h0, 4'h0, 1'b1, 10'h001, 10'h155, "pre_rst_hold");

    // asynchronous reset at hold_cnt=4
    rst = 1'b1;
    #1;
    chk("rst_async", 4'h0, 1'b0, 10'h000, 10'h000);
    @(posedge clk);
    @(negedge clk);
    chk("rst_held", 4'h0, 1'b0, 10'h000, 10'h000);
    req_ledr[9:0] = 10'h2AA;
    rst = 1'b0;

    step(4'h8, 4'h8, 1'b1, 10'h104, 10'h208, "rst_first_req3");
    repeat (7) step(4'h0, 4'h0, 1'b1, 10'h104, 10'h208, "rst_hold3");
    step(4'h9, 4'h1, 1'b1, 10'h2AA, 10'h155, "rr_req0_over_req3");
    repeat (7) step(4'h0, 4'h0, 1'b1, 10'h2AA, 10'h155, "rr_hold0");
    step(4'h0, 4'h0, 1'b0, 10'h000, 10'h000, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
